// File: rtl/kyber_pkg.sv
// kyber_pkg: state encoding, register map and STATUS layout shared by
// the Kyber sequencer and its register window.
package kyber_pkg;

  // State codes are reported verbatim in STATUS[2:0].
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_ENC  = 3'd2,
    ST_DEC  = 3'd3,
    ST_GAP  = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_e;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_TMO    = 32'h8;
  localparam logic [31:0] OFF_IRQ_EN = 32'hC;

  localparam int CTRL_ABORT = 3;

  localparam int SB_KEY_OK   = 4;
  localparam int SB_ENC_OK   = 5;
  localparam int SB_DEC_OK   = 6;
  localparam int SB_SEQ_DONE = 7;
  localparam int SB_TMO_ERR  = 8;
  localparam int SB_OVERRUN  = 9;
  localparam int SB_LO       = SB_KEY_OK;
  localparam int SB_HI       = SB_OVERRUN;

  function automatic seq_state_e first_stage(input logic [2:0] sel);
    seq_state_e s;
    if (sel[0])      s = ST_KEY;
    else if (sel[1]) s = ST_ENC;
    else if (sel[2]) s = ST_DEC;
    else             s = ST_IDLE;
    return s;
  endfunction

endpackage

// File: rtl/kyber_seq_regs.sv
// kyber_seq_regs: CTRL/STATUS/TMO/IRQ_EN window of the Kyber sequencer.
// IRQ_EN and irq exist only when KYBER_SEQ_IRQ_EN is defined.
module kyber_seq_regs
  import kyber_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_7200,
  parameter int          TMO_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             wen_Req,
  input  logic [31:0]      addr_Req,
  input  logic [31:0]      data_Req,
  input  logic [2:0]       state,
  input  logic [5:0]       sticky_set,
  output logic             ctrl_we,
  output logic [3:0]       ctrl_bits,
  output logic             err_clr,
  output logic [TMO_W-1:0] tmo_val,
  output logic [31:0]      data_Resp,
  output logic             irq
);

  logic wr, rd;
  logic hit_ctrl, hit_stat, hit_tmo, hit_ien;
  logic [5:0]       sticky_q, sticky_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      data_resp_q, data_resp_d;
  logic [31:0]      rdata, status_w;
  logic             unused_bits;

  assign wr = req_valid & wen_Req;
  assign rd = req_valid & ~wen_Req;

  assign hit_ctrl = addr_Req == BASE_ADDR + OFF_CTRL;
  assign hit_stat = addr_Req == BASE_ADDR + OFF_STATUS;
  assign hit_tmo  = addr_Req == BASE_ADDR + OFF_TMO;
  assign hit_ien  = addr_Req == BASE_ADDR + OFF_IRQ_EN;

  assign ctrl_we   = wr & hit_ctrl;
  assign ctrl_bits = data_Req[3:0];
  assign err_clr   = wr & hit_stat & data_Req[SB_TMO_ERR];
  assign tmo_val   = tmo_q;
  assign data_Resp = data_resp_q;

  assign status_w = {22'b0, sticky_q, 1'b0, state};

  assign unused_bits = ^{data_Req, hit_ien};

`ifdef KYBER_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && hit_ien) irq_en_d = data_Req[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_en_q <= 1'b0;
    else        irq_en_q <= irq_en_d;
  end

  assign irq = irq_en_q &
               (sticky_q[SB_SEQ_DONE-SB_LO] | sticky_q[SB_TMO_ERR-SB_LO]);
`else
  logic irq_en_q;

  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  // Hardware sets win over a same-cycle W1C so no event is lost.
  always_comb begin
    sticky_d = sticky_q;
    if (wr && hit_stat) sticky_d = sticky_q & ~data_Req[SB_HI:SB_LO];
    sticky_d = sticky_d | sticky_set;
    tmo_d = tmo_q;
    if (wr && hit_tmo) tmo_d = data_Req[TMO_W-1:0];
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_stat: rdata = status_w;
      hit_tmo:  rdata = 32'(tmo_q);
      hit_ien:  rdata = {31'b0, irq_en_q};
      default:  rdata = '0;
    endcase
    data_resp_d = rd ? rdata : data_resp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q    <= '0;
      tmo_q       <= '1;
      data_resp_q <= '0;
    end else begin
      sticky_q    <= sticky_d;
      tmo_q       <= tmo_d;
      data_resp_q <= data_resp_d;
    end
  end

endmodule

// File: rtl/kyber_seq_ctrl.sv
// kyber_seq_ctrl: sequences keygen/encrypt/decrypt stages with timeout.
// Define KYBER_SEQ_IRQ_EN to enable the IRQ_EN register and irq output.
module kyber_seq_ctrl
  import kyber_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_7200,
  parameter int          TMO_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        wen_Req,
  input  logic [31:0] addr_Req,
  input  logic [31:0] data_Req,
  output logic [31:0] data_Resp,
  output logic        key_enable,
  output logic        encryption_enable,
  output logic        decryption_enable,
  input  logic        key_done,
  input  logic        encryption_done,
  input  logic        decryption_done,
  output logic        busy,
  output logic        irq
);

  seq_state_e       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic             ctrl_we, err_clr;
  logic [3:0]       ctrl_bits;
  logic [TMO_W-1:0] tmo_val;
  logic             abort, start;
  logic [2:0]       cur_bit, set_ok;
  logic             cur_done;
  logic             set_done, set_tmo, set_ovr;

  kyber_seq_regs #(
    .BASE_ADDR(BASE_ADDR),
    .TMO_W    (TMO_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .wen_Req   (wen_Req),
    .addr_Req  (addr_Req),
    .data_Req  (data_Req),
    .state     (state_q),
    .sticky_set({set_ovr, set_tmo, set_done, set_ok}),
    .ctrl_we   (ctrl_we),
    .ctrl_bits (ctrl_bits),
    .err_clr   (err_clr),
    .tmo_val   (tmo_val),
    .data_Resp (data_Resp),
    .irq       (irq)
  );

  assign abort = ctrl_we & ctrl_bits[CTRL_ABORT];
  assign start = ctrl_we & (|ctrl_bits[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    set_ok   = '0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    set_ovr  = 1'b0;
    unique case (state_q)
      ST_KEY:  cur_bit = 3'b001;
      ST_ENC:  cur_bit = 3'b010;
      ST_DEC:  cur_bit = 3'b100;
      default: cur_bit = 3'b000;
    endcase
    cur_done = |(cur_bit &
                 {decryption_done, encryption_done, key_done});
    // ERR is sticky until software acknowledges the timeout.
    if (abort && state_q != ST_ERR) begin
      state_d = ST_IDLE;
      sel_d   = '0;
    end else begin
      if (start && state_q != ST_IDLE) set_ovr = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_d   = ctrl_bits[2:0];
            state_d = first_stage(ctrl_bits[2:0]);
            cnt_d   = tmo_val;
          end
        end
        ST_KEY, ST_ENC, ST_DEC: begin
          // A zero load never reaches the expiry value of one.
          if (cur_done) begin
            set_ok  = cur_bit;
            sel_d   = sel_q & ~cur_bit;
            state_d = ST_GAP;
          end else if (cnt_q == TMO_W'(1)) begin
            set_tmo = 1'b1;
            state_d = ST_ERR;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMO_W'(1);
          end
        end
        ST_GAP: begin
          if (sel_q == '0) begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = first_stage(sel_q);
            cnt_d   = tmo_val;
          end
        end
        ST_ERR: begin
          if (err_clr) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_enable        = state_q == ST_KEY;
    encryption_enable = state_q == ST_ENC;
    decryption_enable = state_q == ST_DEC;
    busy              = state_q != ST_IDLE;
  end

endmodule

// File: tb/tb_kyber_seq_ctrl.sv
// tb_kyber_seq_ctrl: directed bench for the Kyber sequencer.
// Stage done inputs come from a delay-programmable responder.
module tb_kyber_seq_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_7200;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_TMO  = BASE + 32'h8;
  localparam logic [31:0] A_IEN  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        wen_Req = 1'b0;
  logic [31:0] addr_Req = '0;
  logic [31:0] data_Req = '0;
  logic [31:0] data_Resp;
  logic        key_enable, encryption_enable, decryption_enable;
  logic        key_done, encryption_done, decryption_done;
  logic        busy, irq;

  int total = 0;
  int bad = 0;
  int dly_key = 0;
  int dly_enc = 0;
  int dly_dec = 0;
  logic inj_enc = 1'b0;
  int kc = 0;
  int ec = 0;
  int dc = 0;

  kyber_seq_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .wen_Req          (wen_Req),
    .addr_Req         (addr_Req),
    .data_Req         (data_Req),
    .data_Resp        (data_Resp),
    .key_enable       (key_enable),
    .encryption_enable(encryption_enable),
    .decryption_enable(decryption_enable),
    .key_done         (key_done),
    .encryption_done  (encryption_done),
    .decryption_done  (decryption_done),
    .busy             (busy),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Responder: done pulses when enable has been high dly cycles (0 = never).
  initial begin
    key_done = 1'b0;
    encryption_done = 1'b0;
    decryption_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      kc = key_enable ? kc + 1 : 0;
      ec = encryption_enable ? ec + 1 : 0;
      dc = decryption_enable ? dc + 1 : 0;
      key_done = (dly_key > 0) && (kc == dly_key);
      encryption_done = inj_enc || ((dly_enc > 0) && (ec == dly_enc));
      decryption_done = (dly_dec > 0) && (dc == dly_dec);
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; wen_Req = 1'b1; addr_Req = a; data_Req = d;
    @(negedge clk);
    req_valid = 1'b0; wen_Req = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    req_valid = 1'b1; wen_Req = 1'b0; addr_Req = a;
    @(negedge clk);
    req_valid = 1'b0;
    d = data_Resp;
  endtask

  function automatic int phase();
    int n;
    n = int'(key_enable) + int'(encryption_enable) + int'(decryption_enable);
    if (n > 1) return 7;
    if (key_enable) return 1;
    if (encryption_enable) return 2;
    if (decryption_enable) return 3;
    return busy ? 4 : 0;
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    total++;
    if ({key_enable, encryption_enable, decryption_enable, busy, irq} !== 5'b0) begin
      bad++;
      $display("FAIL rst_outs got=%b exp=00000",
               {key_enable, encryption_enable, decryption_enable, busy, irq});
    end
    total++; if (data_Resp !== 32'h0) begin bad++; $display("FAIL rst_resp got=%h exp=0", data_Resp); end
    bus_rd(A_TMO, d);
    total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL rst_tmo got=%h exp=0000ffff", d); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
    bus_rd(A_IEN, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_irq_en got=%h exp=0", d); end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    bus_wr(BASE + 32'h10, 32'h7);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL unmapped_wr busy got=%b exp=0", busy); end
    bus_wr(32'h0, 32'h7);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_addr_wr busy got=%b exp=0", busy); end
    bus_rd(BASE + 32'h10, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", d); end
    bus_rd(A_CTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_rd got=%h exp=0", d); end
    bus_wr(A_TMO, 32'hFFFF_1234);
    bus_rd(A_TMO, d);
    total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL tmo_rw got=%h exp=00001234", d); end
  endtask

  task automatic test_sequence;
    logic [31:0] d;
    int e;
    bus_wr(A_TMO, 32'h0);
    dly_key = 5; dly_enc = 5; dly_dec = 5;
    bus_wr(A_CTRL, 32'h7);
    for (int i = 0; i < 19; i++) begin
      e = (i < 5) ? 1 : (i == 5) ? 4 : (i < 11) ? 2 : (i == 11) ? 4 :
          (i < 17) ? 3 : (i == 17) ? 4 : 0;
      total++;
      if (phase() !== e) begin bad++; $display("FAIL seq_phase[%0d] got=%0d exp=%0d", i, phase(), e); end
      @(negedge clk);
    end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'hF0) begin bad++; $display("FAIL seq_status got=%h exp=000000f0", d); end
    bus_wr(A_STAT, 32'h3F0);
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL seq_w1c got=%h exp=0", d); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    dly_key = 0;
    bus_wr(A_TMO, 32'd10);
    bus_wr(A_CTRL, 32'h1);
    repeat (9) @(negedge clk);
    total++; if (key_enable !== 1'b1) begin bad++; $display("FAIL tmo_cycle9 key_en got=%b exp=1", key_enable); end
    @(negedge clk);
    total++;
    if ({key_enable, busy} !== 2'b01) begin
      bad++; $display("FAIL tmo_cycle10 en_busy got=%b exp=01", {key_enable, busy});
    end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h105) begin bad++; $display("FAIL tmo_status got=%h exp=00000105", d); end
    bus_wr(A_STAT, 32'h100);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_exit busy got=%b exp=0", busy); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL err_cleared got=%h exp=0", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    logic seen_key;
    seen_key = 1'b0;
    bus_wr(A_TMO, 32'h0);
    dly_key = 5; dly_enc = 0;
    bus_wr(A_CTRL, 32'h2);
    total++; if (encryption_enable !== 1'b1) begin bad++; $display("FAIL ovr_enc_en got=%b exp=1", encryption_enable); end
    bus_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (key_enable !== 1'b0) seen_key = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_key !== 1'b0) begin bad++; $display("FAIL ovr_key_ran got=%b exp=0", seen_key); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h202) begin bad++; $display("FAIL ovr_status got=%h exp=00000202", d); end
    bus_wr(A_CTRL, 32'h8);
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h200) begin bad++; $display("FAIL ovr_after_abort got=%h exp=00000200", d); end
    bus_wr(A_STAT, 32'h200);
  endtask

  task automatic test_abort;
    logic [31:0] d;
    dly_enc = 0; dly_dec = 0;
    bus_wr(A_CTRL, 32'hF);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_idle busy got=%b exp=0", busy); end
    bus_wr(A_CTRL, 32'h4);
    total++; if (decryption_enable !== 1'b1) begin bad++; $display("FAIL dec_en got=%b exp=1", decryption_enable); end
    repeat (2) @(negedge clk);
    bus_wr(A_CTRL, 32'h8);
    total++;
    if ({decryption_enable, busy} !== 2'b00) begin
      bad++; $display("FAIL abort_dec en_busy got=%b exp=00", {decryption_enable, busy});
    end
    bus_wr(A_CTRL, 32'h2);
    bus_wr(A_CTRL, 32'h9);
    total++; if (phase() !== 0) begin bad++; $display("FAIL abort_prio phase got=%0d exp=0", phase()); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status got=%h exp=0", d); end
  endtask

  task automatic test_tmo_boundary;
    logic [31:0] d;
    bus_wr(A_TMO, 32'd3);
    dly_key = 3;
    bus_wr(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_done busy got=%b exp=0", busy); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h90) begin bad++; $display("FAIL edge_done_status got=%h exp=00000090", d); end
    bus_wr(A_STAT, 32'h3F0);
    dly_key = 4;
    bus_wr(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    total++; if (phase() !== 4) begin bad++; $display("FAIL late_done phase got=%0d exp=4", phase()); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h105) begin bad++; $display("FAIL late_done_status got=%h exp=00000105", d); end
    bus_wr(A_STAT, 32'h100);
  endtask

  task automatic test_tmo_off_and_foreign_done;
    logic [31:0] d;
    bus_wr(A_TMO, 32'h0);
    dly_key = 0;
    bus_wr(A_CTRL, 32'h1);
    inj_enc = 1'b1;
    repeat (2) @(negedge clk);
    inj_enc = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (key_enable !== 1'b1) begin bad++; $display("FAIL tmo_off key_en got=%b exp=1", key_enable); end
    bus_rd(A_STAT, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL foreign_done status got=%h exp=00000001", d); end
    bus_wr(A_CTRL, 32'h8);
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bus_wr(A_TMO, 32'h0);
    dly_key = 2;
    bus_wr(A_IEN, 32'h1);
    bus_rd(A_IEN, d);
`ifdef KYBER_SEQ_IRQ_EN
    total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_en_rd got=%h exp=1", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    bus_wr(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_done got=%b exp=1", irq); end
    bus_wr(A_STAT, 32'h80);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    bus_wr(A_IEN, 32'h0);
`else
    total++; if (d !== 32'h0) begin bad++; $display("FAIL irq_en_rd got=%h exp=0", d); end
    bus_wr(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied got=%b exp=0", irq); end
`endif
    bus_wr(A_STAT, 32'h3F0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    dly_key = 0;
    bus_wr(A_CTRL, 32'h1);
    total++; if (key_enable !== 1'b1) begin bad++; $display("FAIL pre_rst key_en got=%b exp=1", key_enable); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({key_enable, busy} !== 2'b00) begin
      bad++; $display("FAIL async_rst en_busy got=%b exp=00", {key_enable, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(A_TMO, d);
    total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL rst_tmo_again got=%h exp=0000ffff", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_decode();
    test_sequence();
    test_timeout();
    test_overrun();
    test_abort();
    test_tmo_boundary();
    test_tmo_off_and_foreign_done();
    test_irq();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kyber_seq_ctrl.md
KYBER_SEQ_CTRL -- requirements
Module: kyber_seq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_7200, byte address of the register window.
REQ-002 SHALL have parameter TMO_W, default 16, width of the per-stage timeout counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  bus access this cycle.
REQ-006 SHALL have port wen_Req  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_Req  input  32  byte address.
REQ-008 SHALL have port data_Req  input  32  write data.
REQ-009 SHALL have port data_Resp  output  32  registered read data.
REQ-010 SHALL have ports key_enable, encryption_enable, decryption_enable  output  1 each  stage enables.
REQ-011 SHALL have ports key_done, encryption_done, decryption_done  input  1 each  stage completion.
REQ-012 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-013 SHALL have port irq  output  1  level interrupt.

Function
REQ-014 SHALL decode registers: CTRL at BASE+0x0 (W), STATUS at BASE+0x4 (R, W1C), TMO at BASE+0x8 (RW, TMO_W bits, zero-extended), IRQ_EN at BASE+0xC (RW, bit0).
REQ-015 SHALL use CTRL bits: [0] run keygen, [1] run encrypt, [2] run decrypt, [3] abort.
REQ-016 SHALL use STATUS bits: [2:0] state code, [4] key_ok, [5] enc_ok, [6] dec_ok, [7] seq_done, [8] timeout_err, [9] overrun; [4]-[9] sticky.
REQ-017 SHALL implement FSM states IDLE=0, KEY=1, ENC=2, DEC=3, GAP=4, ERR=5.
REQ-018 SHALL, on CTRL write in IDLE with any of bits[2:0] set, latch the bits and enter the first selected stage in order KEY, ENC, DEC; its enable is high the following cycle.
REQ-019 SHALL hold exactly one stage enable high, level, for the whole stage; all enables low outside KEY/ENC/DEC.
REQ-020 SHALL, on the current stage's done, set its ok bit, deassert the enable, spend one cycle in GAP, then enter the next selected stage, or IDLE with seq_done=1 if none remains.
REQ-021 SHALL ignore done inputs of stages other than the current one.
REQ-022 SHALL load the counter from TMO on stage entry and decrement each cycle; at zero without done, enter ERR with timeout_err=1; TMO=0 disables the timeout.
REQ-023 SHALL give done priority over timeout expiry in the same cycle.
REQ-024 SHALL leave ERR only by a STATUS write with bit8 set, which returns to IDLE.
REQ-025 SHALL, on CTRL[3]=1 in any state, return to IDLE the next cycle with enables low; abort takes priority over start bits in the same write.
REQ-026 SHALL ignore a CTRL start while not IDLE and set overrun=1.
REQ-027 SHALL return data_Resp one cycle after a read; unmapped or write-only addresses read 0; unmapped writes are ignored.
REQ-028 SHALL clear each sticky STATUS bit written 1; W1C does not alter the FSM except as stated in REQ-024.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear FSM to IDLE, all enables, busy, irq, data_Resp, STATUS, IRQ_EN and counter; TMO resets to all-ones.
REQ-030 SHALL, on reset mid-stage, drop the enable immediately without waiting for the clock.

Configuration
REQ-031 SHALL, with KYBER_SEQ_IRQ_EN defined, drive irq = IRQ_EN & (seq_done | timeout_err).
REQ-032 SHALL, without KYBER_SEQ_IRQ_EN, tie irq to 0, make IRQ_EN read 0, and ignore writes to it.

Structure
REQ-033 SHALL place the state enum, register offsets and STATUS bit positions in a shared package kyber_pkg.
REQ-034 SHALL implement the register window in sub-module kyber_seq_regs; the FSM and counter stay in kyber_seq_ctrl.

Verification
REQ-035 SHALL test: CTRL=0x7 with each done returned 5 cycles after enable -> KEY, GAP, ENC, GAP, DEC, IDLE; STATUS=0xF0.
REQ-036 SHALL test: TMO=10, CTRL=0x1, key_done never asserted -> ERR 10 cycles after entry; STATUS[8]=1; writing 0x100 to STATUS -> IDLE.
REQ-037 SHALL test: CTRL=0x2 then CTRL=0x1 during ENC -> overrun=1; keygen is not run.
REQ-038 SHALL test: CTRL=0xF in IDLE -> stays IDLE; CTRL=0x8 during DEC -> decryption_enable low next cycle.
REQ-039 SHALL test: TMO=3 with done on the expiry cycle -> stage succeeds with no error.
REQ-040 SHALL test with KYBER_SEQ_IRQ_EN: IRQ_EN=1, run CTRL=0x1 -> irq high after completion; W1C bit7 -> irq low.
